// File: rtl/mlp.sv
// Fixed-weight two-layer perceptron: 16 unsigned 2-bit features, 4 hidden ReLU neurons,
// one thresholded output neuron. The hidden layer is accumulated one feature per clock.
module mlp #(
    parameter int N_IN     = 16,
    parameter int IN_W     = 2,
    parameter int N_HIDDEN = 4,
    parameter int ACC_W    = 8,
    parameter int THRESH   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] data [N_IN-1:0],
    input  logic            new_data,
    output logic            output_ready,
    output logic            mlp_output
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_W-1:0] L_THRESH = ACC_W'(THRESH);
    localparam logic [IDX_W-1:0] L_LAST_IDX = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, DONE} state_t;

    state_t                   r_state;
    logic [IN_W-1:0]          r_data [N_IN-1:0];
    logic [IDX_W-1:0]         r_idx;
    logic signed [ACC_W-1:0]  r_acc [N_HIDDEN-1:0];

    logic signed [ACC_W-1:0]  w_x;
    logic signed [ACC_W-1:0]  w_term [N_HIDDEN-1:0];
    logic signed [ACC_W-1:0]  w_relu [N_HIDDEN-1:0];
    logic signed [ACC_W-1:0]  w_sum;

    // Hidden weight for neuron h at feature i is +1 when (i+h) mod 4 < 2, else -1.
    always_comb begin
        w_x = {{(ACC_W-IN_W){1'b0}}, r_data[r_idx]};
        for (int h = 0; h < N_HIDDEN; h++) begin
            w_term[h] = (((int'(r_idx) + h) % 4) < 2) ? w_x : -w_x;
        end
    end

    // Output neuron: ReLU each hidden sum, then alternate +1/-1 output weights.
    always_comb begin
        w_sum = '0;
        for (int h = 0; h < N_HIDDEN; h++) begin
            w_relu[h] = r_acc[h][ACC_W-1] ? '0 : r_acc[h];
            if ((h % 2) == 0) begin
                w_sum = w_sum + w_relu[h];
            end else begin
                w_sum = w_sum - w_relu[h];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            output_ready <= 1'b0;
            mlp_output   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                r_data[i] <= '0;
            end
            for (int h = 0; h < N_HIDDEN; h++) begin
                r_acc[h] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (new_data) begin
                        r_data       <= data;
                        r_idx        <= '0;
                        output_ready <= 1'b0;
                        r_state      <= ACCUM;
                        for (int h = 0; h < N_HIDDEN; h++) begin
                            r_acc[h] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int h = 0; h < N_HIDDEN; h++) begin
                        r_acc[h] <= r_acc[h] + w_term[h];
                    end
                    if (r_idx == L_LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= OUTPUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                OUTPUT: begin
                    mlp_output   <= (w_sum > L_THRESH);
                    output_ready <= 1'b1;
                    r_state      <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp.sv
// Directed, table-driven bench for mlp: hand-computed class decisions, 17-clock latency,
// mid-evaluation reset, ignored re-requests and back-to-back evaluations.
module tb_mlp;

    logic       clk;
    logic       rst;
    logic [1:0] data [15:0];
    logic       new_data;
    logic       output_ready;
    logic       mlp_output;

    int  errCount;
    int  checkCount;
    logic lastOut;

    typedef struct {
        logic [31:0] bits;
        logic        expOut;
        string       name;
    } vec_t;

    vec_t vecs [8];

    mlp dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .new_data    (new_data),
        .output_ready(output_ready),
        .mlp_output  (mlp_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Feature i occupies bits [2i+1:2i] of the packed vector.
    task automatic setData(input logic [31:0] bits);
        for (int i = 0; i < 16; i++) begin
            data[i] = bits[2*i +: 2];
        end
    endtask

    task automatic applyStimulus(input logic [31:0] bits, input logic expOut, input string name);
        @(negedge clk);
        setData(bits);
        new_data = 1'b1;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        checkOutput({name, "/ready_cleared"}, output_ready, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "/ready_at_16"}, output_ready, 1'b0);
        checkOutput({name, "/out_held"}, mlp_output, lastOut);
        @(posedge clk);
        #1;
        checkOutput({name, "/ready_at_17"}, output_ready, 1'b1);
        checkOutput({name, "/class"}, mlp_output, expOut);
        lastOut = expOut;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        lastOut    = 1'b0;
        new_data   = 1'b0;
        setData(32'h0);
        rst        = 1'b0;

        vecs[0] = '{32'h0000_0000, 1'b0, "all_zero"};
        vecs[1] = '{32'h0000_0005, 1'b1, "x0_x1_one"};
        vecs[2] = '{32'h0000_00C3, 1'b0, "x0_x3_three"};
        vecs[3] = '{32'h0100_0000, 1'b0, "x12_tie"};
        vecs[4] = '{32'h0F0F_0F0F, 1'b1, "mod01_three"};
        vecs[5] = '{32'h0000_0070, 1'b1, "x2_3_x3_1"};
        vecs[6] = '{32'hC3C3_C3C3, 1'b0, "mod03_three"};
        vecs[7] = '{32'hFFFF_FFFF, 1'b0, "all_three"};

        #12;
        checkOutput("reset/ready", output_ready, 1'b0);
        checkOutput("reset/out", mlp_output, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        new_data = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("idle_no_request/ready", output_ready, 1'b0);

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].bits, vecs[v].expOut, vecs[v].name);
            repeat (3) @(negedge clk);
            checkOutput({vecs[v].name, "/done_hold"}, mlp_output, vecs[v].expOut);
        end

        // Re-request with different data during ACCUM must not disturb the running evaluation.
        @(negedge clk);
        setData(32'h0000_0005);
        new_data = 1'b1;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        setData(32'h0000_00C3);
        new_data = 1'b1;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        for (int k = 6; k <= 16; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("ignore/ready_at_16", output_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ignore/ready_at_17", output_ready, 1'b1);
        checkOutput("ignore/class", mlp_output, 1'b1);
        lastOut = 1'b1;

        // Back-to-back: ready is a one-cycle pulse every 18 clocks.
        @(negedge clk);
        setData(32'h0000_0005);
        new_data = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b/ready_%0d", k), output_ready, ((k % 18) == 17));
            if ((k % 18) == 17) begin
                checkOutput($sformatf("b2b/class_%0d", k), mlp_output, 1'b1);
            end
        end
        new_data = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("b2b/final_out", mlp_output, 1'b1);

        // Asynchronous reset in the middle of ACCUM aborts the evaluation.
        @(negedge clk);
        setData(32'h0000_0005);
        new_data = 1'b1;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset/ready", output_ready, 1'b0);
        checkOutput("midreset/out", mlp_output, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("midreset/no_result", output_ready, 1'b0);
        checkOutput("midreset/out_idle", mlp_output, 1'b0);
        lastOut = 1'b0;

        applyStimulus(32'h0000_0005, 1'b1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
